xor_checksum: RTL and testbench

Streaming XOR checksum/parity unit: accepts a frame of WIDTH-bit words over a valid/ready input, accumulates the bitwise XOR of all beats, and presents the checksum, its parity bit and the beat count on a valid/ready output when the frame's last beat is accepted. It is the parametrised, clocked successor to the 1-bit gate-level XOR in the logic-gates library. It sits between a word source (test pattern generator, UART RX framer) and any consumer that needs a per-frame integrity word.

---
 rtl/xor_pkg.sv | 15 +
 rtl/xor_word.sv | 15 +
 rtl/xor_checksum.sv | 130 +++++++++++++
 tb/tb_xor_checksum.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_pkg.sv
// Shared types and helpers for the streaming XOR checksum unit.
package xor_pkg;

    // Frame state: collecting beats, or presenting a finished result.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width needed to hold a beat count from 0 up to and including max_len.
    function automatic int unsigned cw_of(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage : xor_pkg

// File: rtl/xor_word.sv
// Word-wide bitwise XOR assembled from one 1-bit XOR gate per bit.
module xor_word #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_c
);

    // One gate per bit position.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor u_gate (sum_c[i], a[i], b[i]);
    end

endmodule : xor_word

// File: rtl/xor_checksum.sv
// Streaming XOR checksum: folds a frame of words into one checksum word,
// a parity bit and a saturating beat count, then holds the result until
// the consumer takes it.
module xor_checksum
    import xor_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_LEN    = 16,
    parameter bit          ODD_PARITY = 1'b0,
    localparam int unsigned CW        = cw_of(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;

    logic             accept_c;
    logic             at_max_c;
    logic [WIDTH-1:0] acc_next_c;
    logic [CW-1:0]    cnt_next_c;
    logic             ovf_next_c;

    // Accumulator update: running sum XOR the incoming word.
    xor_word #(
        .WIDTH (WIDTH)
    ) u_acc_xor (
        .a     (acc_q),
        .b     (in_data),
        .sum_c (acc_next_c)
    );

    // Beat acceptance and saturating count / sticky overflow for this beat.
    always_comb begin
        accept_c   = in_valid & in_ready;
        at_max_c   = (cnt_q == MAX_CNT);
        cnt_next_c = at_max_c ? cnt_q : cnt_q + CW'(1);
        ovf_next_c = ovf_q | at_max_c;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: close the frame on its last beat, release on result handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (accept_c && in_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake flags are registered copies of the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == ACCUM);
            out_valid <= (state_d == HOLD);
        end
    end

    // Running frame accumulators; cleared when the frame closes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept_c) begin
            if (in_last) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc_q <= acc_next_c;
                cnt_q <= cnt_next_c;
                ovf_q <= ovf_next_c;
            end
        end
    end

    // Result registers: captured on the last beat, held until the next frame closes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_sum      <= '0;
            out_parity   <= ODD_PARITY;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (accept_c && in_last) begin
            out_sum      <= acc_next_c;
            out_parity   <= (^acc_next_c) ^ ODD_PARITY;
            out_count    <= cnt_next_c;
            out_overflow <= ovf_next_c;
        end
    end

endmodule : xor_checksum

// File: tb/tb_xor_checksum.sv
// Bench for xor_checksum: an even-parity and an odd-parity instance share
// one stimulus stream; a frame-level model predicts every result.
module tb_xor_checksum;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CW      = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_ready;

    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    logic             odd_in_ready;
    logic             odd_out_valid;
    logic [WIDTH-1:0] odd_out_sum;
    logic             odd_out_parity;
    logic [CW-1:0]    odd_out_count;
    logic             odd_out_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WIDTH-1:0] sum;
        int               count;
        logic             ovf;
    } result_t;

    logic [WIDTH-1:0] beats[$];
    result_t          expq[$];
    logic             pend_valid = 1'b0;
    int               since_rst  = 0;

    xor_checksum #(
        .WIDTH      (WIDTH),
        .MAX_LEN    (MAX_LEN),
        .ODD_PARITY (1'b0)
    ) dut_even (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_parity   (out_parity),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    xor_checksum #(
        .WIDTH      (WIDTH),
        .MAX_LEN    (MAX_LEN),
        .ODD_PARITY (1'b1)
    ) dut_odd (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (odd_in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (odd_out_valid),
        .out_ready    (out_ready),
        .out_sum      (odd_out_sum),
        .out_parity   (odd_out_parity),
        .out_count    (odd_out_count),
        .out_overflow (odd_out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: record accepted beats, build the expected result on the last one.
    always @(posedge clk) begin
        if (!rst_n) begin
            beats.delete();
            expq.delete();
            pend_valid = 1'b0;
            since_rst  = 0;
        end else begin
            result_t r;
            since_rst  = since_rst + 1;
            pend_valid = 1'b0;
            if (out_valid && out_ready && expq.size() > 0) begin
                void'(expq.pop_front());
            end
            if (in_valid && in_ready) begin
                beats.push_back(in_data);
                if (in_last) begin
                    r.sum = '0;
                    foreach (beats[i]) r.sum = r.sum ^ beats[i];
                    r.count = (beats.size() > MAX_LEN) ? MAX_LEN : beats.size();
                    r.ovf   = (beats.size() > MAX_LEN);
                    expq.push_back(r);
                    beats.delete();
                    pend_valid = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && since_rst >= 1) begin
            check("in_ready_excl", 32'(in_ready), 32'(!out_valid));
            check("odd_in_ready", 32'(odd_in_ready), 32'(in_ready));
            check("odd_out_valid", 32'(odd_out_valid), 32'(out_valid));
            if (pend_valid) check("latency", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("m_sum", 32'(out_sum), 32'(expq[0].sum));
                    check("m_parity", 32'(out_parity), 32'(^expq[0].sum));
                    check("m_count", 32'(out_count), 32'(expq[0].count));
                    check("m_ovf", 32'(out_overflow), 32'(expq[0].ovf));
                    check("m_odd_sum", 32'(odd_out_sum), 32'(expq[0].sum));
                    check("m_odd_parity", 32'(odd_out_parity), 32'(~^expq[0].sum));
                    check("m_odd_count", 32'(odd_out_count), 32'(expq[0].count));
                    check("m_odd_ovf", 32'(odd_out_overflow), 32'(expq[0].ovf));
                end
            end
        end
    end

    // Present one beat from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [WIDTH-1:0] s, input logic p,
                              input int c, input logic o);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(out_sum), 32'(s));
        check({tag, "_parity"}, 32'(out_parity), 32'(p));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(o));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_parity_even", 32'(out_parity), 32'd0);
        check("rst_parity_odd", 32'(odd_out_parity), 32'd1);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-beat frame.
        send(8'hA5, 1'b1);
        expect_out("single", 8'hA5, 1'b0, 1, 1'b0);

        // Three-beat frame, then backpressure on the result.
        wait_ready();
        out_ready = 1'b0;
        send(8'h0F, 1'b0);
        check("b2b_ready1", 32'(in_ready), 32'd1);
        send(8'hF0, 1'b0);
        check("b2b_ready2", 32'(in_ready), 32'd1);
        send(8'h3C, 1'b1);
        expect_out("three", 8'hC3, 1'b0, 3, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(out_sum), 32'hC3);
            check("bp_count", 32'(out_count), 32'd3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        send(8'h11, 1'b1);
        expect_out("after_bp", 8'h11, 1'b0, 1, 1'b0);

        // Overflow: six beats into a four-beat counter.
        for (int i = 0; i < 5; i++) send(8'h01, 1'b0);
        send(8'h01, 1'b1);
        expect_out("ovf", 8'h00, 1'b0, 4, 1'b1);
        send(8'h02, 1'b1);
        expect_out("post_ovf", 8'h02, 1'b1, 1, 1'b0);

        // Reset in the middle of a frame discards the partial sum.
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        send(8'h55, 1'b1);
        expect_out("midrst_frame", 8'h55, 1'b0, 1, 1'b0);

        // Parity polarity on both instances.
        send(8'h00, 1'b1);
        check("odd_zero_sum", 32'(odd_out_sum), 32'h00);
        check("odd_zero_parity", 32'(odd_out_parity), 32'd1);
        check("even_zero_parity", 32'(out_parity), 32'd0);
        send(8'h01, 1'b1);
        check("odd_one_parity", 32'(odd_out_parity), 32'd0);
        check("even_one_parity", 32'(out_parity), 32'd1);

        repeat (4) @(negedge clk);
        check("drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_xor_checksum
